// File: rtl/s_o_pkg.sv
// s_o_pkg: shared definitions between the S/O command sequencer and the
// s_o_function responder: one-hot symbol codes, FSM state encoding and a
// small helper for sizing the unit counter.
package s_o_pkg;

    // Symbol request codes on func_start (11 is invalid and ignored).
    localparam logic [1:0] FUNC_NONE = 2'b00;
    localparam logic [1:0] FUNC_S    = 2'b10;
    localparam logic [1:0] FUNC_O    = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ON   = 3'd1,
        ST_OFF  = 3'd2,
        ST_TAIL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/s_o_unit_timer.sv
// s_o_unit_timer: divides clk down to Morse time units.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : forces the cycle counter back to 0
//   run         : counting enable
//   unit_tick   : one-cycle pulse on the last cycle of every UNIT_CYCLES
//                 cycles while run is high
module s_o_unit_timer #(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic unit_tick
);

    // Counter runs 0..UNIT_CYCLES-1 and clears on its terminal count, so it
    // never wraps. With UNIT_CYCLES == 1 it sits at 0 and ticks every cycle.
    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (run)
            cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end

    assign unit_tick = run && (cnt_q == TERM);

endmodule

// File: rtl/s_o_function.sv
// s_o_function: responder to the S/O command sequencer. Plays the Morse
// pattern for the requested symbol on pin_out and pulses func_done once the
// pattern and its trailing letter gap are complete.
//   clk, rst_n  : clock, asynchronous active-low reset
//   func_start  : symbol request (10 = S, 01 = O, 00 = none, 11 = invalid)
//   func_done   : one-cycle completion pulse
//   pin_out     : registered Morse output, active-high
module s_o_function
    import s_o_pkg::*;
#(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int DIT_UNITS   = 1,
    parameter int DAH_UNITS   = 3,
    parameter int GAP_UNITS   = 1,
    parameter int TAIL_UNITS  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] func_start,
    output logic       func_done,
    output logic       pin_out
);

    localparam int MAXU = max4(DAH_UNITS, DIT_UNITS, GAP_UNITS, TAIL_UNITS);
    localparam int UW   = $clog2(MAXU + 1);

    // Unit targets held as "last unit index" so expiry is a single compare.
    localparam logic [UW-1:0] DIT_LAST  = UW'(DIT_UNITS - 1);
    localparam logic [UW-1:0] DAH_LAST  = UW'(DAH_UNITS - 1);
    localparam logic [UW-1:0] GAP_LAST  = UW'(GAP_UNITS - 1);
    localparam logic [UW-1:0] TAIL_LAST = UW'(TAIL_UNITS - 1);

    state_t        state_q, state_d;
    logic          sym_o_q, sym_o_d;     // 1 = O (dah elements), 0 = S
    logic [1:0]    elem_q,  elem_d;
    logic [UW-1:0] unit_q,  unit_d;
    logic          armed_q, armed_d;
    logic          pin_q,   pin_d;
    logic          done_q,  done_d;

    logic          unit_tick;
    logic          timing;
    logic          req_valid;
    logic [UW-1:0] on_last;

    // The cycle counter only runs while a timed state is active; holding it
    // clear otherwise guarantees every element starts on a fresh unit.
    assign timing    = (state_q == ST_ON) || (state_q == ST_OFF) || (state_q == ST_TAIL);
    assign req_valid = (func_start == FUNC_S) || (func_start == FUNC_O);
    assign on_last   = sym_o_q ? DAH_LAST : DIT_LAST;

    s_o_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!timing),
        .run       (timing),
        .unit_tick (unit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sym_o_q <= 1'b0;
            elem_q  <= '0;
            unit_q  <= '0;
            armed_q <= 1'b1;
            pin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_o_q <= sym_o_d;
            elem_q  <= elem_d;
            unit_q  <= unit_d;
            armed_q <= armed_d;
            pin_q   <= pin_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sym_o_d = sym_o_q;
        elem_d  = elem_q;
        unit_d  = unit_q;
        armed_d = armed_q;
        pin_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Arming only happens here, so a request still held from the
                // previous symbol can never retrigger.
                if (armed_q && req_valid) begin
                    state_d = ST_ON;
                    sym_o_d = (func_start == FUNC_O);
                    elem_d  = '0;
                    unit_d  = '0;
                    pin_d   = 1'b1;
                end else if (func_start == FUNC_NONE) begin
                    armed_d = 1'b1;
                end
            end
            ST_ON: begin
                pin_d = 1'b1;
                if (unit_tick) begin
                    if (unit_q == on_last) begin
                        unit_d  = '0;
                        pin_d   = 1'b0;
                        state_d = (elem_q == 2'd2) ? ST_TAIL : ST_OFF;
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (unit_tick) begin
                    if (unit_q == GAP_LAST) begin
                        unit_d  = '0;
                        elem_d  = elem_q + 2'd1;
                        pin_d   = 1'b1;
                        state_d = ST_ON;
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (unit_tick) begin
                    if (unit_q == TAIL_LAST) begin
                        unit_d  = '0;
                        done_d  = 1'b1;
                        armed_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pin_out   = pin_q;
    assign func_done = done_q;

endmodule

// File: tb/tb_s_o_function.sv
module tb_s_o_function;
    import s_o_pkg::*;

    localparam int U    = 4;
    localparam int DIT  = 1;
    localparam int DAH  = 3;
    localparam int GAP  = 1;
    localparam int TAIL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] func_start = FUNC_NONE;
    logic       func_done;
    logic       pin_out;

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;
    int done_cnt = 0;
    int hi_cnt = 0;
    int last_done = 0;

    s_o_function #(
        .UNIT_CYCLES (U),
        .DIT_UNITS   (DIT),
        .DAH_UNITS   (DAH),
        .GAP_UNITS   (GAP),
        .TAIL_UNITS  (TAIL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .func_start (func_start),
        .func_done  (func_done),
        .pin_out    (pin_out)
    );

    always #5 clk = ~clk;

    // Reference model: tracks only "busy since edge A, k cycles ago" and the
    // arming flag; expected outputs come from the symbol timing arithmetic.
    logic m_busy  = 1'b0;
    logic m_armed = 1'b1;
    logic m_o     = 1'b0;
    int   m_k     = 0;

    function automatic int on_len(input logic o);
        return U * (o ? DAH : DIT);
    endfunction

    function automatic int total_len(input logic o);
        return 3 * on_len(o) + 2 * GAP * U + TAIL * U;
    endfunction

    function automatic logic exp_pin();
        if (!m_busy) return 1'b0;
        return (m_k < 3 * on_len(m_o) + 2 * GAP * U) &&
               ((m_k % (on_len(m_o) + GAP * U)) < on_len(m_o));
    endfunction

    function automatic logic exp_done();
        return m_busy && (m_k == total_len(m_o));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_armed <= 1'b1;
            m_k     <= 0;
        end else if (m_busy) begin
            if (m_k == total_len(m_o)) begin
                m_busy  <= 1'b0;
                m_armed <= 1'b0;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (m_armed && (func_start == FUNC_S || func_start == FUNC_O)) begin
            m_busy <= 1'b1;
            m_k    <= 0;
            m_o    <= (func_start == FUNC_O);
        end else if (func_start == FUNC_NONE) begin
            m_armed <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample on the falling edge and compare against the model.
    task automatic cyc();
        @(negedge clk);
        cyc_no++;
        check("pin_out", pin_out, exp_pin());
        check("func_done", func_done, exp_done());
        if (func_done === 1'b1) begin
            done_cnt++;
            last_done = cyc_no;
        end
        if (pin_out === 1'b1) hi_cnt++;
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pin", pin_out, 1'b0);
        check("async_rst_done", func_done, 1'b0);
    endtask

    // Issue a symbol and wait for done; exp_lat is the done cycle relative
    // to acceptance edge A.
    task automatic run_sym(input logic [1:0] sym, input bit drop, input int exp_lat);
        int  n0;
        bit  got;
        func_start = sym;
        n0 = cyc_no;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc();
            if (func_done === 1'b1) got = 1'b1;
        end
        check_int("done_latency", got ? (cyc_no - n0 - 1) : -1, exp_lat);
        if (drop) func_start = FUNC_NONE;
    endtask

    initial begin
        int d0, h0, d1, d2, n0;
        bit got;

        // Reset state
        #1;
        check("reset_pin", pin_out, 1'b0);
        check("reset_done", func_done, 1'b0);
        cyc(); cyc(); cyc();
        rst_n = 1'b1;

        // Idle with no request, then a reset at an odd phase
        d0 = done_cnt; h0 = hi_cnt;
        for (int i = 0; i < 100; i++) cyc();
        check_int("idle_done_cnt", done_cnt - d0, 0);
        check_int("idle_pin_high", hi_cnt - h0, 0);
        async_reset_check();
        cyc();
        rst_n = 1'b1;
        cyc();

        // S then O
        run_sym(FUNC_S, 1'b1, 32);
        h0 = hi_cnt;
        cyc(); cyc();
        run_sym(FUNC_O, 1'b1, 56);
        check_int("o_pin_high_cycles", hi_cnt - h0, 36);
        cyc(); cyc();

        // SOS via sequencer handshake: clear on done, next request one edge later
        run_sym(FUNC_S, 1'b1, 32);
        d1 = last_done;
        cyc(); cyc();
        run_sym(FUNC_O, 1'b1, 56);
        d2 = last_done;
        check_int("sos_gap_1", d2 - d1, 59);
        cyc(); cyc();
        run_sym(FUNC_S, 1'b0, 32);
        check_int("sos_gap_2", last_done - d2, 35);

        // Request held after done must not retrigger
        d0 = done_cnt; h0 = hi_cnt;
        for (int i = 0; i < 50; i++) cyc();
        check_int("held_no_retrigger", done_cnt - d0, 0);
        check_int("held_pin_low", hi_cnt - h0, 0);
        func_start = FUNC_NONE;
        cyc();
        run_sym(FUNC_S, 1'b1, 32);
        cyc(); cyc();

        // Invalid request in IDLE
        func_start = 2'b11;
        d0 = done_cnt; h0 = hi_cnt;
        for (int i = 0; i < 20; i++) cyc();
        check_int("invalid_no_done", done_cnt - d0, 0);
        check_int("invalid_pin_low", hi_cnt - h0, 0);
        func_start = FUNC_NONE;
        cyc();

        // Mid-operation request changes are ignored
        func_start = FUNC_S;
        n0 = cyc_no;
        got = 1'b0;
        h0 = hi_cnt;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc();
            if (cyc_no - n0 - 1 == 4) func_start = FUNC_O;
            if (cyc_no - n0 - 1 == 9) func_start = FUNC_NONE;
            if (func_done === 1'b1) got = 1'b1;
        end
        check_int("midop_latency", got ? (cyc_no - n0 - 1) : -1, 32);
        check_int("midop_pin_high_cycles", hi_cnt - h0, 12);
        func_start = FUNC_NONE;
        cyc(); cyc();

        // Reset at cycle 20 of an O, then a fresh S
        func_start = FUNC_O;
        for (int i = 0; i < 21; i++) cyc();
        check("o_cycle20_pin", pin_out, 1'b1);
        d0 = done_cnt;
        func_start = FUNC_NONE;
        async_reset_check();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) cyc();
        check_int("reset_no_done", done_cnt - d0, 0);
        run_sym(FUNC_S, 1'b1, 32);

        // Random request traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) func_start = 2'($urandom_range(0, 3));
            cyc();
            if ($urandom_range(0, 249) == 0) begin
                async_reset_check();
                cyc();
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
